// File: rtl/sram_axis_reader.sv
// sram_axis_reader
// Streams len contiguous words from one SRAM bank onto an AXI4-Stream master.
// A 2-entry FIFO absorbs the one-cycle SRAM read latency and tready
// backpressure. Reads are throttled so the buffered words plus the in-flight
// read never exceed the FIFO depth, so 1 word/cycle is sustained with tready high.
// Optional build macro: SRAM_READER_PERF_EN adds the stall_cycles counter port.
module sram_axis_reader #(
  parameter int C_AXIS_TDATA_WIDTH = 64,
  parameter int LEN_WIDTH          = 16,
  parameter int MAX_ADDR_WIDTH     = 12,
  parameter int SRAM_WIDTH_O       = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [MAX_ADDR_WIDTH-1:0]       base_addr,
  input  logic [2:0]                      bank_idx,
  input  logic [LEN_WIDTH-1:0]            len,
  output logic                            busy,
  output logic                            done,
  output logic                            sram_out_en,
  output logic [2:0]                      sram_out_idx,
  output logic [MAX_ADDR_WIDTH-1:0]       sram_out_addr,
  input  logic [SRAM_WIDTH_O-1:0]         sram_out_data,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready
`ifdef SRAM_READER_PERF_EN
  ,
  output logic [31:0]                     stall_cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Transfer parameters captured on an accepted start
  logic [MAX_ADDR_WIDTH-1:0] base_reg;
  logic [2:0]                bank_reg;
  logic [LEN_WIDTH-1:0]      len_reg;

  // Progress counters
  logic [LEN_WIDTH-1:0]      issue_cnt_reg;
  logic [LEN_WIDTH-1:0]      beat_cnt_reg;
  logic                      inflight_reg;

  // Two-entry FIFO between the SRAM read port and the stream
  logic [C_AXIS_TDATA_WIDTH-1:0] fifo_mem_reg [2];
  logic                          wr_ptr_reg;
  logic                          rd_ptr_reg;
  logic [1:0]                    fifo_count_reg;
  logic [1:0]                    fifo_count_next;

  logic       start_accept;
  logic       push;
  logic       pop;
  logic [2:0] occupancy;
  logic       issue_ok;
  logic       last_issue;
  logic       drain_empty;

  assign start_accept  = (state_reg == S_IDLE) && start;
  assign m_axis_tvalid = (fifo_count_reg != 2'd0);
  assign pop           = m_axis_tvalid && m_axis_tready;
  // Data returns one cycle after the request, so the push is the delayed enable
  assign push          = inflight_reg;
  // Words that will occupy the FIFO once this cycle's pop and the in-flight read land
  assign occupancy     = 3'(fifo_count_reg) + 3'(inflight_reg) - 3'(pop);
  assign issue_ok      = (occupancy < 3'd2);
  assign last_issue    = (issue_cnt_reg == len_reg - LEN_WIDTH'(1));
  // Nothing in flight and the FIFO empties at the end of this cycle
  assign drain_empty   = !inflight_reg && (fifo_count_reg == (pop ? 2'd1 : 2'd0));

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = (len != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (issue_ok && last_issue) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_empty) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // FSM-driven outputs
  always_comb begin
    busy        = (state_reg != S_IDLE);
    done        = (state_reg == S_DONE);
    sram_out_en = (state_reg == S_RUN) && issue_ok;
  end

  // Capture transfer parameters and advance issue / beat counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      base_reg      <= '0;
      bank_reg      <= '0;
      len_reg       <= '0;
      issue_cnt_reg <= '0;
      beat_cnt_reg  <= '0;
      inflight_reg  <= 1'b0;
    end else begin
      if (start_accept) begin
        base_reg      <= base_addr;
        bank_reg      <= bank_idx;
        len_reg       <= len;
        issue_cnt_reg <= '0;
        beat_cnt_reg  <= '0;
      end else begin
        if (sram_out_en) begin
          issue_cnt_reg <= issue_cnt_reg + LEN_WIDTH'(1);
        end
        if (pop) begin
          beat_cnt_reg <= beat_cnt_reg + LEN_WIDTH'(1);
        end
      end
      inflight_reg <= sram_out_en;
    end
  end

  // Read address wraps naturally at the address width
  assign sram_out_idx  = bank_reg;
  assign sram_out_addr = base_reg + MAX_ADDR_WIDTH'(issue_cnt_reg);

  assign fifo_count_next = fifo_count_reg + 2'(push) - 2'(pop);

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg     <= 1'b0;
      rd_ptr_reg     <= 1'b0;
      fifo_count_reg <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      fifo_count_reg <= fifo_count_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo_entry
      // Load this entry when the returning read targets it
      always_ff @(posedge clk) begin
        if (!rst) begin
          fifo_mem_reg[gi] <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          fifo_mem_reg[gi] <= sram_out_data[C_AXIS_TDATA_WIDTH-1:0];
        end
      end
    end
  endgenerate

  // Head of the FIFO only moves on a pop, so data/last hold while stalled
  assign m_axis_tdata = fifo_mem_reg[rd_ptr_reg];
  assign m_axis_tlast = m_axis_tvalid && (beat_cnt_reg == len_reg - LEN_WIDTH'(1));
  assign m_axis_tkeep = '1;

  // Flag a push into a full FIFO that is not draining in the same cycle
  always_ff @(posedge clk) begin
    if (rst && push && !pop) begin
      assert (fifo_count_reg != 2'd2);
    end
  end

`ifdef SRAM_READER_PERF_EN
  logic [31:0] stall_cnt_reg;

  // Count cycles a valid beat is held off by the sink, saturating
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
    end else if (start_accept) begin
      stall_cnt_reg <= '0;
    end else if (m_axis_tvalid && !m_axis_tready && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_sram_axis_reader.sv
// Testbench for sram_axis_reader: drives transfers against a behavioural SRAM
// and compares observed reads/beats/done timing with expectations derived
// from the block's transfer rules.
module tb_sram_axis_reader;
  localparam int DW = 64;
  localparam int LW = 16;
  localparam int AW = 12;
  localparam int SW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [2:0]    bank_idx = '0;
  logic [LW-1:0] len = '0;
  logic          busy;
  logic          done;
  logic          sram_out_en;
  logic [2:0]    sram_out_idx;
  logic [AW-1:0] sram_out_addr;
  logic [SW-1:0] sram_out_data = '0;
  logic [DW-1:0] m_axis_tdata;
  logic [DW/8-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b1;
`ifdef SRAM_READER_PERF_EN
  logic [31:0]   stall_cycles;
`endif

  always #5 clk = ~clk;

  sram_axis_reader #(
    .C_AXIS_TDATA_WIDTH(DW),
    .LEN_WIDTH(LW),
    .MAX_ADDR_WIDTH(AW),
    .SRAM_WIDTH_O(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .bank_idx(bank_idx),
    .len(len),
    .busy(busy),
    .done(done),
    .sram_out_en(sram_out_en),
    .sram_out_idx(sram_out_idx),
    .sram_out_addr(sram_out_addr),
    .sram_out_data(sram_out_data),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready)
`ifdef SRAM_READER_PERF_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] salt = 32'h0;

  // Content of SRAM word at an address: addr * 0x0101, upper half salted
  function automatic logic [DW-1:0] sram_word(input logic [AW-1:0] a, input logic [31:0] s);
    logic [DW-1:0] w;
    w = DW'(a) * DW'(16'h0101);
    w = w ^ {s, 32'h0};
    return w;
  endfunction

  // One-cycle read latency SRAM; garbage when not read
  always @(posedge clk) begin
    if (sram_out_en) sram_out_data <= sram_word(sram_out_addr, salt);
    else sram_out_data <= {$urandom, $urandom};
  end

  // Observations of one transfer
  logic [AW-1:0] o_addr[$];
  logic [2:0]    o_idx[$];
  int            o_en_cyc[$];
  logic [DW-1:0] o_data[$];
  logic          o_last[$];
  int            o_beat_cyc[$];
  int            o_done_cyc[$];
  int            o_stalls, o_unstable, o_max_out, o_idle_cyc, o_valid_seen;
  bit            o_timeout;
  logic          o_busy_after_rst, o_valid_after_rst;

  // Drive one transfer (start in cycle 0) and record what the DUT does
  task automatic run_xfer(input logic [AW-1:0] b, input logic [2:0] bk, input logic [LW-1:0] n,
                          input int mode, input int restart_cyc, input int rst_cyc, input int max_cyc);
    int issued, accepted;
    logic prev_stall, prev_last;
    logic [DW-1:0] prev_data;
    bit seen_done;
    issued = 0; accepted = 0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0; seen_done = 0;
    o_addr.delete(); o_idx.delete(); o_en_cyc.delete();
    o_data.delete(); o_last.delete(); o_beat_cyc.delete(); o_done_cyc.delete();
    o_stalls = 0; o_unstable = 0; o_max_out = 0; o_idle_cyc = -1; o_valid_seen = 0;
    o_timeout = 1; o_busy_after_rst = 1'bx; o_valid_after_rst = 1'bx;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge clk);
      start     = (cyc == 0) || (cyc == restart_cyc);
      base_addr = (cyc == 0) ? b : (b ^ AW'(12'h5a5));
      bank_idx  = (cyc == 0) ? bk : ~bk;
      len       = (cyc == 0) ? n : n + LW'(7);
      rst       = (cyc != rst_cyc);
      if (mode == 0) m_axis_tready = 1'b1;
      else if (mode == 1) m_axis_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      else m_axis_tready = 1'($urandom_range(0, 1));
      #1;
      if (sram_out_en) begin
        o_addr.push_back(sram_out_addr);
        o_idx.push_back(sram_out_idx);
        o_en_cyc.push_back(cyc);
        issued++;
      end
      if (m_axis_tvalid) o_valid_seen++;
      if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last))
        o_unstable++;
      if (m_axis_tvalid && m_axis_tready) begin
        o_data.push_back(m_axis_tdata);
        o_last.push_back(m_axis_tlast);
        o_beat_cyc.push_back(cyc);
        accepted++;
      end
      if (m_axis_tvalid && !m_axis_tready) o_stalls++;
      if (issued - accepted > o_max_out) o_max_out = issued - accepted;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
        o_busy_after_rst  = busy;
        o_valid_after_rst = m_axis_tvalid;
      end
      if (done) begin
        o_done_cyc.push_back(cyc);
        seen_done = 1;
      end
      if (rst_cyc < 0 && seen_done && !busy) begin
        o_idle_cyc = cyc;
        o_timeout = 0;
        break;
      end
      if (rst_cyc >= 0 && cyc == rst_cyc + 3) begin
        o_timeout = 0;
        break;
      end
    end
    start = 1'b0;
    rst = 1'b1;
    m_axis_tready = 1'b1;
    $display("xfer base=%h bank=%0d len=%0d mode=%0d reads=%0d beats=%0d dones=%0d idle@%0d stalls=%0d",
             b, bk, n, mode, o_addr.size(), o_data.size(), o_done_cyc.size(), o_idle_cyc, o_stalls);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (sram_out_en !== 1'b0) begin n_bad++; $display("FAIL reset_en got=%b exp=0", sram_out_en); end
    n_cmp++; if (sram_out_idx !== 3'd0) begin n_bad++; $display("FAIL reset_idx got=%0d exp=0", sram_out_idx); end
    n_cmp++; if (sram_out_addr !== '0) begin n_bad++; $display("FAIL reset_addr got=%h exp=0", sram_out_addr); end
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); end
    n_cmp++; if (m_axis_tlast !== 1'b0) begin n_bad++; $display("FAIL reset_tlast got=%b exp=0", m_axis_tlast); end
    n_cmp++; if (m_axis_tdata !== '0) begin n_bad++; $display("FAIL reset_tdata got=%h exp=0", m_axis_tdata); end
    n_cmp++; if (m_axis_tkeep !== 8'hff) begin n_bad++; $display("FAIL tkeep got=%h exp=ff", m_axis_tkeep); end
`ifdef SRAM_READER_PERF_EN
    n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL reset_stall got=%0d exp=0", stall_cycles); end
`endif
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp_d [4];
    exp_d[0] = 64'h1010; exp_d[1] = 64'h1111; exp_d[2] = 64'h1212; exp_d[3] = 64'h1313;
    salt = 32'h0;
    run_xfer(AW'(12'h010), 3'd3, LW'(4), 0, -1, -1, 50);
    n_cmp++; if (o_timeout) begin n_bad++; $display("FAIL basic_timeout got=timeout exp=idle"); end
    n_cmp++; if (o_addr.size() != 4) begin n_bad++; $display("FAIL basic_nreads got=%0d exp=4", o_addr.size()); end
    for (int k = 0; k < 4 && k < o_addr.size(); k++) begin
      n_cmp++; if (o_addr[k] !== AW'(12'h010 + k) || o_en_cyc[k] != 1 + k || o_idx[k] !== 3'd3) begin
        n_bad++; $display("FAIL basic_read%0d got=addr %h cyc %0d bank %0d exp=addr %h cyc %0d bank 3",
                          k, o_addr[k], o_en_cyc[k], o_idx[k], 12'h010 + k, 1 + k);
      end
    end
    n_cmp++; if (o_data.size() != 4) begin n_bad++; $display("FAIL basic_nbeats got=%0d exp=4", o_data.size()); end
    for (int k = 0; k < 4 && k < o_data.size(); k++) begin
      n_cmp++; if (o_data[k] !== exp_d[k] || o_beat_cyc[k] != 3 + k || o_last[k] !== (k == 3)) begin
        n_bad++; $display("FAIL basic_beat%0d got=%h cyc %0d last %b exp=%h cyc %0d last %b",
                          k, o_data[k], o_beat_cyc[k], o_last[k], exp_d[k], 3 + k, k == 3);
      end
    end
    n_cmp++; if (o_done_cyc.size() != 1 || o_done_cyc[0] != 7) begin
      n_bad++; $display("FAIL basic_done got=%0d pulses first@%0d exp=1 pulse @7", o_done_cyc.size(),
                        o_done_cyc.size() > 0 ? o_done_cyc[0] : -1);
    end
    n_cmp++; if (o_idle_cyc != 8) begin n_bad++; $display("FAIL basic_idle got=%0d exp=8", o_idle_cyc); end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] b;
    b = AW'($urandom);
    salt = $urandom;
    run_xfer(b, 3'd5, LW'(6), 1, -1, -1, 100);
    n_cmp++; if (o_timeout) begin n_bad++; $display("FAIL bp_timeout got=timeout exp=idle"); end
    n_cmp++; if (o_data.size() != 6) begin n_bad++; $display("FAIL bp_nbeats got=%0d exp=6", o_data.size()); end
    for (int k = 0; k < 6 && k < o_data.size(); k++) begin
      n_cmp++; if (o_data[k] !== sram_word(b + AW'(k), salt) || o_last[k] !== (k == 5)) begin
        n_bad++; $display("FAIL bp_beat%0d got=%h last %b exp=%h last %b", k, o_data[k], o_last[k],
                          sram_word(b + AW'(k), salt), k == 5);
      end
    end
    n_cmp++; if (o_unstable != 0) begin n_bad++; $display("FAIL bp_stable got=%0d changes exp=0", o_unstable); end
    n_cmp++; if (o_max_out > 2) begin n_bad++; $display("FAIL bp_buffered got=%0d exp<=2", o_max_out); end
    n_cmp++; if (o_stalls == 0) begin n_bad++; $display("FAIL bp_stall_seen got=0 exp>0"); end
    n_cmp++; if (o_done_cyc.size() != 1) begin n_bad++; $display("FAIL bp_done got=%0d exp=1", o_done_cyc.size()); end
`ifdef SRAM_READER_PERF_EN
    n_cmp++; if (stall_cycles !== 32'(o_stalls)) begin
      n_bad++; $display("FAIL bp_stall_count got=%0d exp=%0d", stall_cycles, o_stalls);
    end
`endif
  endtask

  task automatic test_len_zero();
    run_xfer(AW'(12'h123), 3'd1, LW'(0), 0, -1, -1, 20);
    n_cmp++; if (o_done_cyc.size() != 1 || o_done_cyc[0] != 1) begin
      n_bad++; $display("FAIL len0_done got=%0d pulses first@%0d exp=1 pulse @1", o_done_cyc.size(),
                        o_done_cyc.size() > 0 ? o_done_cyc[0] : -1);
    end
    n_cmp++; if (o_addr.size() != 0) begin n_bad++; $display("FAIL len0_reads got=%0d exp=0", o_addr.size()); end
    n_cmp++; if (o_valid_seen != 0) begin n_bad++; $display("FAIL len0_tvalid got=%0d exp=0", o_valid_seen); end
    n_cmp++; if (o_idle_cyc != 2) begin n_bad++; $display("FAIL len0_idle got=%0d exp=2", o_idle_cyc); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] b;
    logic [AW-1:0] exp_a [4];
    b = '1;
    b = b - AW'(1);
    exp_a[0] = b; exp_a[1] = '1; exp_a[2] = '0; exp_a[3] = AW'(1);
    salt = $urandom;
    run_xfer(b, 3'd2, LW'(4), 0, -1, -1, 50);
    n_cmp++; if (o_addr.size() != 4) begin n_bad++; $display("FAIL wrap_nreads got=%0d exp=4", o_addr.size()); end
    for (int k = 0; k < 4 && k < o_addr.size(); k++) begin
      n_cmp++; if (o_addr[k] !== exp_a[k]) begin
        n_bad++; $display("FAIL wrap_addr%0d got=%h exp=%h", k, o_addr[k], exp_a[k]);
      end
    end
    n_cmp++; if (o_data.size() != 4 || o_data[2] !== sram_word('0, salt)) begin
      n_bad++; $display("FAIL wrap_data got=%0d beats exp=4 beats, beat2=%h", o_data.size(), sram_word('0, salt));
    end
  endtask

  task automatic test_restart_ignored();
    logic [AW-1:0] b;
    b = AW'($urandom);
    salt = $urandom;
    run_xfer(b, 3'd4, LW'(5), 0, 2, -1, 60);
    n_cmp++; if (o_addr.size() != 5) begin n_bad++; $display("FAIL restart_nreads got=%0d exp=5", o_addr.size()); end
    for (int k = 0; k < 5 && k < o_addr.size(); k++) begin
      n_cmp++; if (o_addr[k] !== b + AW'(k) || o_idx[k] !== 3'd4) begin
        n_bad++; $display("FAIL restart_read%0d got=%h bank %0d exp=%h bank 4", k, o_addr[k], o_idx[k], b + AW'(k));
      end
    end
    n_cmp++; if (o_data.size() != 5) begin n_bad++; $display("FAIL restart_nbeats got=%0d exp=5", o_data.size()); end
    n_cmp++; if (o_done_cyc.size() != 1 || o_done_cyc[0] != 8) begin
      n_bad++; $display("FAIL restart_done got=%0d pulses first@%0d exp=1 pulse @8", o_done_cyc.size(),
                        o_done_cyc.size() > 0 ? o_done_cyc[0] : -1);
    end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] b;
    salt = $urandom;
    run_xfer(AW'($urandom), 3'd6, LW'(8), 0, -1, 4, 20);
    n_cmp++; if (o_valid_after_rst !== 1'b0) begin n_bad++; $display("FAIL rstmid_tvalid got=%b exp=0", o_valid_after_rst); end
    n_cmp++; if (o_busy_after_rst !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got=%b exp=0", o_busy_after_rst); end
    n_cmp++; if (o_done_cyc.size() != 0) begin n_bad++; $display("FAIL rstmid_done got=%0d exp=0", o_done_cyc.size()); end
    b = AW'($urandom);
    run_xfer(b, 3'd0, LW'(2), 0, -1, -1, 30);
    n_cmp++; if (o_data.size() != 2) begin n_bad++; $display("FAIL rstnew_nbeats got=%0d exp=2", o_data.size()); end
    for (int k = 0; k < 2 && k < o_data.size(); k++) begin
      n_cmp++; if (o_data[k] !== sram_word(b + AW'(k), salt) || o_last[k] !== (k == 1)) begin
        n_bad++; $display("FAIL rstnew_beat%0d got=%h last %b exp=%h last %b", k, o_data[k], o_last[k],
                          sram_word(b + AW'(k), salt), k == 1);
      end
    end
    n_cmp++; if (o_done_cyc.size() != 1 || o_done_cyc[0] != 5) begin
      n_bad++; $display("FAIL rstnew_done got=%0d pulses first@%0d exp=1 pulse @5", o_done_cyc.size(),
                        o_done_cyc.size() > 0 ? o_done_cyc[0] : -1);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      logic [AW-1:0] b;
      logic [LW-1:0] n;
      b = AW'($urandom);
      n = LW'($urandom_range(1, 12));
      salt = $urandom;
      run_xfer(b, 3'($urandom), n, 2, -1, -1, 400);
      n_cmp++; if (o_timeout) begin n_bad++; $display("FAIL rand%0d_timeout got=timeout exp=idle", t); end
      n_cmp++; if (o_data.size() != int'(n) || o_addr.size() != int'(n)) begin
        n_bad++; $display("FAIL rand%0d_counts got=%0d beats %0d reads exp=%0d", t, o_data.size(), o_addr.size(), n);
      end
      for (int k = 0; k < int'(n) && k < o_data.size(); k++) begin
        n_cmp++; if (o_data[k] !== sram_word(b + AW'(k), salt) || o_last[k] !== (k == int'(n) - 1)) begin
          n_bad++; $display("FAIL rand%0d_beat%0d got=%h last %b exp=%h last %b", t, k, o_data[k], o_last[k],
                            sram_word(b + AW'(k), salt), k == int'(n) - 1);
        end
      end
      n_cmp++; if (o_unstable != 0 || o_max_out > 2 || o_done_cyc.size() != 1) begin
        n_bad++; $display("FAIL rand%0d_flow got=unstable %0d buffered %0d dones %0d exp=0 <=2 1",
                          t, o_unstable, o_max_out, o_done_cyc.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_len_zero();
    test_wrap();
    test_restart_ignored();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_axis_reader.md
# sram_axis_reader

Streams a contiguous block of words out of one SRAM bank onto an AXI4-Stream master. It drives the SRAM controller's output read port (`sram_out_en` / `sram_out_idx` / `sram_out_addr` / `sram_out_data`) and feeds the DMA egress path. It absorbs the one-cycle SRAM read latency and `tready` backpressure with a 2-entry FIFO, and sustains 1 word/cycle when `tready` is held high.

## Interface
- `C_AXIS_TDATA_WIDTH`, 64, stream data width; equals the SRAM word width used.
- `LEN_WIDTH`, 16, width of the transfer length in words.
- `clk` in 1 — clock.
- `rst` in 1 — reset, synchronous, active-low.
- `start` in 1 — single-cycle request; sampled only in IDLE.
- `base_addr` in MAX_ADDR_WIDTH — first word address, captured on `start`.
- `bank_idx` in 3 — SRAM bank, captured on `start`.
- `len` in LEN_WIDTH — number of words, captured on `start`.
- `busy` out 1 — high in every state except IDLE.
- `done` out 1 — one-cycle pulse at transfer end.
- `sram_out_en` out 1 — read request to the controller.
- `sram_out_idx` out 3 — equals the captured `bank_idx`.
- `sram_out_addr` out MAX_ADDR_WIDTH — read address.
- `sram_out_data` in SRAM_WIDTH_O — read data, valid one cycle after `sram_out_en`; the low C_AXIS_TDATA_WIDTH bits are used.
- `m_axis_tdata` out C_AXIS_TDATA_WIDTH — stream data.
- `m_axis_tkeep` out C_AXIS_TDATA_WIDTH/8 — constant all ones.
- `m_axis_tvalid` out 1 — stream valid.
- `m_axis_tlast` out 1 — high on the final beat.
- `m_axis_tready` in 1 — stream ready.
- `stall_cycles` out 32 — present only with SRAM_READER_PERF_EN.

## Operation
- States:
  - **IDLE**: `start` with `len != 0` → RUN; `start` with `len == 0` → DONE.
  - **RUN**: issue reads; after the last read is issued → DRAIN.
  - **DRAIN**: wait for the in-flight read and the FIFO to empty → DONE.
  - **DONE**: one cycle, `done = 1`; then → IDLE.
- `start` is ignored whenever the state is not IDLE.
- Read issue rule in RUN: assert `sram_out_en` when `fifo_count + inflight - pop < 2`.
  - `inflight` is 1 if `sram_out_en` was high in the previous cycle, else 0.
  - `pop` is `tvalid & tready` in the current cycle.
- Address for read k is `base_addr + k`, computed modulo 2^MAX_ADDR_WIDTH (wraps, no error).
- The issue counter counts 0..len-1; the beat counter counts accepted beats.
- `tlast` is high when the FIFO head is beat `len-1`.
- FIFO write: the cycle after `sram_out_en`, `sram_out_data` is pushed.
  - The issue rule guarantees no overflow; an overflow is a design bug and is flagged by a simulation assertion.
- `tvalid` is high whenever the FIFO is non-empty; `tdata` / `tlast` are stable while `tvalid & !tready`.
- Bank access is exclusive: the top-level sequencer issues `start` only when no higher-priority client uses `bank_idx` for the transfer's duration.

## Timing
- Reset values: `busy = 0`, `done = 0`, `sram_out_en = 0`, `sram_out_idx = 0`, `sram_out_addr = 0`, `tvalid = 0`, `tlast = 0`, `tdata = 0`, `stall_cycles = 0`; state = IDLE; FIFO empty; counters cleared.
- Latency with `start` in cycle 0:
  - `sram_out_en` in cycle 1 (addr = base).
  - FIFO write at end of cycle 2.
  - First `tvalid` in cycle 3.
- With `tready` held high: one beat per cycle; last beat in cycle `len + 2`; `done` in cycle `len + 3`; IDLE in cycle `len + 4`.
- `len == 0`: `done` in cycle 1, no reads, no beats.
- Backpressure: with `tready` low, at most 2 words are buffered and no further reads are issued. Reads resume the cycle `tready` returns high.
- Reset mid-transfer (`rst = 0` at any edge): all state returns to reset values in the next cycle. Any in-flight read data is discarded and `done` is not pulsed.

## Configuration
- `SRAM_READER_PERF_EN` defined:
  - `stall_cycles` counts cycles with `tvalid & !tready`.
  - It is cleared on reset and on accepted `start`, and saturates at 2^32-1.
- Not defined: the `stall_cycles` port and its counter are absent.

## Test plan
- `len = 4`, `base = 0x10`, `bank = 3`, `tready = 1`, SRAM model returning `addr * 0x0101`:
  - reads 0x10..0x13 in cycles 1..4;
  - beats 0x1010..0x1313 in cycles 3..6, `tlast` on 0x1313;
  - `done` in cycle 7.
- `len = 6`, `tready` toggling 1,0,0,1,…:
  - data order is preserved and `tdata` is stable while stalled;
  - FIFO never exceeds 2;
  - with PERF_EN, `stall_cycles` equals the count of stalled valid cycles.
- `len = 0`: `done` in cycle 1, `sram_out_en` and `tvalid` never asserted.
- `base = 2^MAX_ADDR_WIDTH - 2`, `len = 4`: addresses are max-1, max, 0, 1.
- `start` pulsed again during RUN is ignored; only the first transfer's `len` beats appear.
- `rst` low in cycle 4 of an 8-word transfer: `tvalid` / `busy` are 0 next cycle with no `done`; a new 2-word transfer afterwards completes correctly.
